add_sub_pipe: RTL and testbench

Pipelined, parametrised adder/subtractor that replaces the single-cycle add/sub unit in datapaths where a full-width carry chain limits clock frequency. The carry chain is split into CHUNK-bit slices, one per pipeline stage. The block adds signed saturating modes and a full flag set (carry, overflow, zero, negative), and moves operands and results over valid/ready handshakes. It sits between operand-fetch and writeback in the course processor datapath at one result per clock.

---
 rtl/add_sub_pipe.sv | 157 +++++++++++++++
 tb/tb_add_sub_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_pipe.sv
// add_sub_pipe
// Pipelined adder/subtractor with optional signed saturation. The carry
// chain is cut into CHUNK-bit slices and each pipeline stage resolves one
// slice, so the critical path is a single CHUNK-bit add. Latency is
// WIDTH/CHUNK cycles and throughput is one operation per clock.
//
// Parameters
//   WIDTH  operand/result width (must be a multiple of CHUNK)
//   CHUNK  slice width resolved per stage
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operand transfer request
//   in_ready     operands can be accepted this cycle
//   in_A, in_B   operands
//   in_op        00 add, 01 sub, 10 saturating add, 11 saturating sub
//   out_valid    result present
//   out_ready    downstream accepts result
//   out          result (clamped in saturating modes)
//   out_carry    raw carry out of the MSB (sub: 1 means A >= B unsigned)
//   out_ovrflow  signed overflow of the raw, unsaturated operation
//   out_zero     out == 0, after saturation
//   out_neg      out[WIDTH-1], after saturation

module add_sub_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_carry,
    output logic             out_ovrflow,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int L = WIDTH / CHUNK;

    // One global enable: the whole pipe, bubbles included, either shifts
    // together or freezes together. It only freezes when a finished result
    // is waiting and downstream refuses it.
    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < L; k++) begin : stg
        // REM: operand bits not yet added, including this stage's slice.
        // DONE: result bits known once this stage has added its slice.
        localparam int REM  = WIDTH - k * CHUNK;
        localparam int DONE = (k + 1) * CHUNK;

        logic [REM-1:0]   src_a;
        logic [REM-1:0]   src_b;
        logic             src_sat;
        logic             src_c;
        logic             src_v;
        logic [CHUNK-1:0] sum;
        logic             cout;
        logic [DONE-1:0]  nr;

        // The slice adder: lowest unprocessed slice plus incoming carry.
        assign {cout, sum} = {1'b0, src_a[CHUNK-1:0]}
                           + {1'b0, src_b[CHUNK-1:0]}
                           + {{CHUNK{1'b0}}, src_c};

        if (k == 0) begin : g_src_in
            // Subtraction is A + ~B + 1; the +1 enters as the first carry.
            // Only the saturate bit of the op travels further down the pipe,
            // since B has already been conditioned here.
            assign src_a   = in_A;
            assign src_b   = in_op[0] ? ~in_B : in_B;
            assign src_sat = in_op[1];
            assign src_c   = in_op[0];
            assign src_v   = in_valid;
            assign nr      = sum;
        end else begin : g_src_pipe
            assign src_a   = stg[k-1].g_reg.a_q;
            assign src_b   = stg[k-1].g_reg.b_q;
            assign src_sat = stg[k-1].g_reg.sat_q;
            assign src_c   = stg[k-1].g_reg.c_q;
            assign src_v   = stg[k-1].g_reg.v_q;
            assign nr      = {sum, stg[k-1].g_reg.r_q};
        end

        if (k < L - 1) begin : g_reg
            // Skew registers: the still-unadded upper operand slices move
            // along with the finished lower result bits and the slice carry.
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;
            logic [DONE-1:0]      r_q;
            logic                 sat_q;
            logic                 c_q;
            logic                 v_q;

            // Only the valid bit needs reset; data behind an invalid stage
            // is never observed.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (adv) begin
                    v_q   <= src_v;
                    a_q   <= src_a[REM-1:CHUNK];
                    b_q   <= src_b[REM-1:CHUNK];
                    r_q   <= nr;
                    sat_q <= src_sat;
                    c_q   <= cout;
                end
            end
        end else begin : g_last
            logic             ovf;
            logic [WIDTH-1:0] res;

            // Overflow uses the conditioned B: both operand signs equal and
            // the raw sign differs. A saturating op clamps toward A's sign.
            always_comb begin
                ovf = (src_a[CHUNK-1] == src_b[CHUNK-1]) &&
                      (nr[WIDTH-1] != src_a[CHUNK-1]);
                res = nr;
                if (src_sat && ovf) begin
                    res = src_a[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end

            // Result register: flags are registered alongside the value so
            // everything stays frozen together during a downstream stall.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid   <= 1'b0;
                    out         <= '0;
                    out_carry   <= 1'b0;
                    out_ovrflow <= 1'b0;
                    out_zero    <= 1'b0;
                    out_neg     <= 1'b0;
                end else if (adv) begin
                    out_valid   <= src_v;
                    out         <= res;
                    out_carry   <= cout;
                    out_ovrflow <= ovf;
                    out_zero    <= (res == '0);
                    out_neg     <= res[WIDTH-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb_add_sub_pipe
// Bench for add_sub_pipe: a 4-stage instance (WIDTH=32, CHUNK=8) for the
// main scenarios and a single-stage instance (CHUNK=32) for the degenerate
// depth case. Expected results come from an arithmetic model working on
// 64-bit signed integers and are queued at acceptance, popped at delivery.

module tb_add_sub_pipe;

    localparam int WIDTH = 32;
    localparam int L     = 4;

    logic             clk;
    logic             rst;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_carry;
    logic             out_ovrflow;
    logic             out_zero;
    logic             out_neg;

    logic             in_valid1;
    logic             in_ready1;
    logic [WIDTH-1:0] in_a1;
    logic [WIDTH-1:0] in_b1;
    logic [1:0]       in_op1;
    logic             out_valid1;
    logic             out_ready1;
    logic [WIDTH-1:0] out_res1;
    logic             out_carry1;
    logic             out_ovrflow1;
    logic             out_zero1;
    logic             out_neg1;

    int total = 0;
    int bad   = 0;

    // Expected {out, carry, ovrflow, zero, neg} in acceptance order.
    logic [35:0] sb_q[$];

    add_sub_pipe #(.WIDTH(WIDTH), .CHUNK(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_a), .in_B(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out_res), .out_carry(out_carry), .out_ovrflow(out_ovrflow),
        .out_zero(out_zero), .out_neg(out_neg)
    );

    add_sub_pipe #(.WIDTH(WIDTH), .CHUNK(32)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_A(in_a1), .in_B(in_b1), .in_op(in_op1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out(out_res1), .out_carry(out_carry1), .out_ovrflow(out_ovrflow1),
        .out_zero(out_zero1), .out_neg(out_neg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic done in wide signed integers, independent of
    // the slice structure.
    function automatic logic [35:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [1:0]  op);
        longint      sa;
        longint      sb;
        longint      full;
        logic [32:0] us;
        logic        c;
        logic        v;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op[0]) begin
            full = sa - sb;
            c    = (a >= b);
        end else begin
            full = sa + sb;
            us   = {1'b0, a} + {1'b0, b};
            c    = us[32];
        end
        v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
        r = full[31:0];
        if (op[1] && v) r = (full > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        return {r, c, v, (r == 32'h0), r[31]};
    endfunction

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_op      = 2'b00;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        in_a1      = '0;
        in_b1      = '0;
        in_op1     = 2'b00;
        out_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({out_valid, out_res, out_carry, out_ovrflow, out_zero, out_neg} !== 37'h0) begin
            bad++;
            $display("[TB] FAIL reset_state: got valid=%b out=%h flags=%b%b%b%b, expected all 0",
                     out_valid, out_res, out_carry, out_ovrflow, out_zero, out_neg);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        total++;
        if ({out_valid1, out_res1} !== 33'h0) begin
            bad++;
            $display("[TB] FAIL reset_state_depth1: got valid=%b out=%h expected 0",
                     out_valid1, out_res1);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [0:10];
        logic [31:0] vb [0:10];
        logic [1:0]  vo [0:10];
        logic [35:0] ve [0:10];
        int          lat;
        va = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'd5, 32'd7, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
               32'h8000_0000, 32'h8000_0000, 32'd10, 32'h0000_1234, 32'h7FFF_FFFF};
        vb = '{32'h0000_0001, 32'h0000_0001, 32'd7, 32'd5, 32'h0000_0001, 32'h0000_0001,
               32'h0000_0001, 32'hFFFF_FFFF, 32'd3, 32'h0000_1234, 32'hFFFF_FFFF};
        vo = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
        // {out, carry, ovrflow, zero, neg}
        ve = '{{32'h0000_0100, 4'b0000}, {32'h0000_0000, 4'b1010},
               {32'hFFFF_FFFE, 4'b0001}, {32'h0000_0002, 4'b1000},
               {32'h7FFF_FFFF, 4'b0100}, {32'h8000_0000, 4'b0101},
               {32'h8000_0000, 4'b1101}, {32'h8000_0000, 4'b1101},
               {32'h0000_0007, 4'b1000}, {32'h0000_0000, 4'b1010},
               {32'h7FFF_FFFF, 4'b0100}};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_a      = va[i];
            in_b      = vb[i];
            in_op     = vo[i];
            @(negedge clk);
            in_valid = 1'b0;
            lat      = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            total++;
            if (out_valid !== 1'b1 || lat != L) begin
                bad++;
                $display("[TB] FAIL latency[%0d]: got %0d cycles (valid=%b) expected %0d",
                         i, lat, out_valid, L);
            end
            total++;
            if ({out_res, out_carry, out_ovrflow, out_zero, out_neg} !== ve[i]) begin
                bad++;
                $display("[TB] FAIL directed[%0d]: got %h %b%b%b%b expected %h %b",
                         i, out_res, out_carry, out_ovrflow, out_zero, out_neg,
                         ve[i][35:4], ve[i][3:0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        logic        stall_prev = 1'b0;
        logic [36:0] held = '0;
        logic [35:0] e;
        sb_q.delete();
        while (got < 16 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (stall_prev) begin
                total++;
                if ({out_valid, out_res, out_carry, out_ovrflow, out_zero, out_neg} !== held) begin
                    bad++;
                    $display("[TB] FAIL stall_hold: got %b %h %b%b%b%b expected %h",
                             out_valid, out_res, out_carry, out_ovrflow, out_zero, out_neg, held);
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            in_op     = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       in_a = 32'h7FFF_FFFF;
                1:       in_a = 32'h8000_0000;
                default: in_a = $urandom;
            endcase
            in_b     = ($urandom_range(0, 2) == 0) ? 32'(2'($urandom_range(0, 3)) - 2'd1) : $urandom;
            in_valid = (sent < 16) && ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                bad++;
                $display("[TB] FAIL in_ready_rule: got %b expected %b (valid=%b ready=%b)",
                         in_ready, !(out_valid && !out_ready), out_valid, out_ready);
            end
            if (out_valid && out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_result: got %h expected no result", out_res);
                end else begin
                    e = sb_q.pop_front();
                    if ({out_res, out_carry, out_ovrflow, out_zero, out_neg} !== e) begin
                        bad++;
                        $display("[TB] FAIL b2b_result[%0d]: got %h %b%b%b%b expected %h %b",
                                 got, out_res, out_carry, out_ovrflow, out_zero, out_neg,
                                 e[35:4], e[3:0]);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(in_a, in_b, in_op));
                sent++;
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_valid, out_res, out_carry, out_ovrflow, out_zero, out_neg};
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != 16 || sent != 16 || sb_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL b2b_complete: got %0d results from %0d sent, %0d pending, expected 16/16/0",
                     got, sent, sb_q.size());
        end
        repeat (L + 1) @(negedge clk);
    endtask

    task automatic test_reset_in_flight();
        logic seen = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 32'h0000_1000 + 32'(i);
            in_b     = 32'h0000_0001;
            in_op    = 2'b00;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({out_valid, out_res, out_carry, out_ovrflow, out_zero, out_neg} !== 37'h0) begin
            bad++;
            $display("[TB] FAIL midreset_state: got valid=%b out=%h flags=%b%b%b%b expected all 0",
                     out_valid, out_res, out_carry, out_ovrflow, out_zero, out_neg);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_in_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("[TB] FAIL midreset_ghost: got a result after reset expected none");
        end
    endtask

    task automatic test_depth1();
        logic [31:0] va [0:1];
        logic [31:0] vb [0:1];
        logic [1:0]  vo [0:1];
        logic [35:0] ve [0:1];
        int          lat;
        va = '{32'h0000_00FF, 32'h8000_0000};
        vb = '{32'h0000_0001, 32'h0000_0001};
        vo = '{2'b00, 2'b11};
        ve = '{{32'h0000_0100, 4'b0000}, {32'h8000_0000, 4'b1101}};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out_ready1 = 1'b1;
            in_valid1  = 1'b1;
            in_a1      = va[i];
            in_b1      = vb[i];
            in_op1     = vo[i];
            @(negedge clk);
            in_valid1 = 1'b0;
            lat       = 1;
            while (!out_valid1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            total++;
            if (out_valid1 !== 1'b1 || lat != 1) begin
                bad++;
                $display("[TB] FAIL depth1_latency[%0d]: got %0d cycles expected 1", i, lat);
            end
            total++;
            if ({out_res1, out_carry1, out_ovrflow1, out_zero1, out_neg1} !== ve[i]) begin
                bad++;
                $display("[TB] FAIL depth1_result[%0d]: got %h %b%b%b%b expected %h %b",
                         i, out_res1, out_carry1, out_ovrflow1, out_zero1, out_neg1,
                         ve[i][35:4], ve[i][3:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_in_flight();
        test_depth1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
